exception_source_reporter: RTL
==============================

# exception_source_reporter

Source-side endpoint of the exception interface: sits inside an execution unit (load/store, branch, CSR), captures exceptions detected by the unit's pipeline, and holds the oldest one stable as a valid/code/id/tval request toward the global control unit until that unit acks it. After an ack it suppresses further reports until the post-flush discard window has closed. It also asserts a hold to the owning unit while a report is outstanding.

## Interface
- MAX_IDS, 8: number of in-flight instruction IDs; power of two.
- ID_W, $clog2(MAX_IDS): ID width.
- CODE_W, 5: exception code width.
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- detect_valid  in  1  unit pipeline detected an exception this cycle.
- detect_code  in  CODE_W  code of detected exception.
- detect_id  in  ID_W  instruction ID of the faulting op.
- detect_tval  in  32  trap value.
- oldest_id  in  ID_W  ID of the oldest in-flight instruction, the age reference.
- discard  in  1  global write-back suppress, high during the post-flush discard window.
- ack  in  1  global control accepted the exception.
- exc_valid  out  1  exception request pending.
- exc_code  out  CODE_W  held code.
- exc_id  out  ID_W  held ID.
- exc_tval  out  32  held tval.
- unit_hold  out  1  owning unit stops issuing while high.

## Operation
- FSM states: IDLE, PENDING, DRAIN_WAIT, DRAIN.
- IDLE: on detect_valid, capture code/id/tval and go to PENDING. detect_valid is ignored while discard=1.
- PENDING: exc_valid=1 and the outputs are held stable.
  - If detect_valid is high and ack is low, compute age(x) = (x - oldest_id) mod MAX_IDS, unsigned ID_W-bit subtract.
  - If age(detect_id) < age(exc_id), replace all three held fields. Equal age keeps the held entry.
  - On ack, go to DRAIN_WAIT. A detect in the same cycle as ack is dropped.
- DRAIN_WAIT: when discard=1, go to DRAIN. All detects are dropped.
- DRAIN: when discard=0, go to IDLE. All detects are dropped.
- unit_hold = (state != IDLE).
- exc_valid = (state == PENDING).
- ack while not in PENDING is ignored.
- Reset puts the FSM in IDLE. All outputs are 0, including code, id and tval.
- Reset asserted mid-PENDING or mid-DRAIN returns the block to IDLE the next cycle and drops the held exception.

## Timing
- Detect-to-report latency is 1 cycle: detect at cycle t gives exc_valid=1 at t+1, carrying the detected fields.
- A replacement at cycle t is visible on the outputs at t+1. exc_valid stays high continuously.
- ack at t gives exc_valid=0 and state DRAIN_WAIT at t+1. This holds even if ack stays high for multiple cycles.
- In DRAIN_WAIT, discard rising at t gives DRAIN at t+1. discard falling at t' gives IDLE at t'+1.
- A detect is first accepted in the IDLE cycle.
- If discard is already high when ack arrives, the sequence is ack at t, DRAIN_WAIT at t+1, discard still high, DRAIN at t+2.
- All outputs are registered or decoded from registered state. There is no combinational path from inputs to outputs.
- oldest_id wrap: age arithmetic is modulo MAX_IDS. The ID at oldest_id has age 0; oldest_id-1 is the youngest.

## Test plan
- Basic: detect id=3, code=4, tval=0x1000 at t with oldest_id=2 -> at t+1 exc_valid=1, id=3, code=4, tval=0x1000, unit_hold=1.
- Older replacement across wrap (MAX_IDS=8, oldest_id=6):
  - hold id=1 (age 3); detect id=7 (age 1) -> outputs become id=7 next cycle.
  - Then detect id=0 (age 2) -> no change.
- Ack/drain:
  - ack at t -> exc_valid=0 at t+1.
  - detects during DRAIN_WAIT and DRAIN are dropped.
  - discard high 3 cycles then low -> IDLE one cycle after the fall, unit_hold=0.
  - A new detect is then reported.
- Same-cycle ack+detect: ack and detect id=5 in the same cycle -> detect dropped; after the drain sequence, exc_valid stays 0.
- Reset: apply rst while PENDING with id=2 -> next cycle all outputs 0, state IDLE; ack afterwards ignored.
- Detect during discard in IDLE: detect with discard=1 -> exc_valid stays 0.

Source files
------------

// File: rtl/exception_source_reporter.sv
// Source-side exception reporter: captures the oldest detected exception, holds it
// as a request until acked, then waits out the post-flush discard window.
module exception_source_reporter #(
    parameter int MAX_IDS = 8,
    parameter int ID_W    = $clog2(MAX_IDS),
    parameter int CODE_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              detect_valid,
    input  logic [CODE_W-1:0] detect_code,
    input  logic [ID_W-1:0]   detect_id,
    input  logic [31:0]       detect_tval,
    input  logic [ID_W-1:0]   oldest_id,
    input  logic              discard,
    input  logic              ack,
    output logic              exc_valid,
    output logic [CODE_W-1:0] exc_code,
    output logic [ID_W-1:0]   exc_id,
    output logic [31:0]       exc_tval,
    output logic              unit_hold
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PENDING    = 2'd1,
        DRAIN_WAIT = 2'd2,
        DRAIN      = 2'd3
    } state_t;

    state_t            state_p1, state_d;
    logic [CODE_W-1:0] code_p1;
    logic [ID_W-1:0]   id_p1;
    logic [31:0]       tval_p1;
    logic              load;

    // Distance from the oldest in-flight ID; the ID_W-bit subtract wraps mod MAX_IDS.
    function automatic logic [ID_W-1:0] age_of(input logic [ID_W-1:0] x,
                                               input logic [ID_W-1:0] base);
        logic [ID_W-1:0] diff;
        diff = x - base;
        return diff;
    endfunction

    always_comb begin
        state_d = state_p1;
        load    = 1'b0;
        case (state_p1)
            IDLE: begin
                if (detect_valid && !discard) begin
                    load    = 1'b1;
                    state_d = PENDING;
                end
            end
            PENDING: begin
                // An ack wins over a same-cycle detect, which is dropped.
                if (ack) begin
                    state_d = DRAIN_WAIT;
                end else if (detect_valid &&
                             (age_of(detect_id, oldest_id) < age_of(id_p1, oldest_id))) begin
                    load = 1'b1;
                end
            end
            DRAIN_WAIT: begin
                if (discard) state_d = DRAIN;
            end
            DRAIN: begin
                if (!discard) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Registered state and held exception fields
    always_ff @(posedge clk) begin
        if (rst) begin
            state_p1 <= IDLE;
            code_p1  <= '0;
            id_p1    <= '0;
            tval_p1  <= '0;
        end else begin
            state_p1 <= state_d;
            if (load) begin
                code_p1 <= detect_code;
                id_p1   <= detect_id;
                tval_p1 <= detect_tval;
            end
        end
    end

    assign exc_valid = (state_p1 == PENDING);
    assign unit_hold = (state_p1 != IDLE);
    assign exc_code  = code_p1;
    assign exc_id    = id_p1;
    assign exc_tval  = tval_p1;

endmodule
